// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state type for the OAM DMA engine.
package gb_mem_pkg;

    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam int unsigned OAM_BYTES     = 160;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] DMA_IDLE_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_t;

    // Source address of byte idx on a 256-byte page; idx stays below 0xA0, so no carry.
    function automatic logic [15:0] dma_src_addr(input logic [7:0] page, input logic [7:0] idx);
        return {page, idx};
    endfunction

    // Destination address of byte idx inside OAM.
    function automatic logic [15:0] dma_oam_addr(input logic [7:0] idx);
        return OAM_BASE + {8'h00, idx};
    endfunction

endpackage

// File: rtl/mem_if.sv
// Simple 16-bit address / 8-bit data memory port shared by the MMU and its masters.
interface mem_if;

    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_value,
        output write_enable,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_value,
        input  write_enable,
        output read_out
    );

endinterface

// File: rtl/dma_slot_timer.sv
// Byte-slot sequencer for the OAM DMA: a slot counter inside each byte plus the
// byte index, with strobes for the capture slot, the slot before the write, the
// write slot itself and the final byte.
module dma_slot_timer
    import gb_mem_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned READ_LATENCY    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    output logic       slot_last,
    output logic       slot_pre_last,
    output logic       slot_capture,
    output logic       byte_last,
    output logic [7:0] idx,
    output logic [7:0] idx_step
);

    localparam int unsigned SLOT_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;

    logic [SLOT_W-1:0] slot_q;
    logic [7:0]        idx_q;

    assign slot_last     = (slot_q == SLOT_W'(CYCLES_PER_BYTE - 1));
    assign slot_pre_last = (slot_q == SLOT_W'(CYCLES_PER_BYTE - 2));
    assign slot_capture  = (slot_q == SLOT_W'(READ_LATENCY));
    assign byte_last     = (idx_q == 8'(OAM_BYTES - 1));
    assign idx           = idx_q;

    // Index the byte that will be current after one more step; never wraps past the last byte.
    always_comb begin
        idx_step = idx_q;
        if (slot_last && !byte_last) begin
            idx_step = idx_q + 8'd1;
        end
    end

    // Slot counter wraps every byte; the byte index advances on the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            idx_q  <= 8'h00;
        end else if (clr) begin
            slot_q <= '0;
            idx_q  <= 8'h00;
        end else if (step) begin
            if (slot_last) begin
                slot_q <= '0;
                if (!byte_last) begin
                    idx_q <= idx_q + 8'd1;
                end
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: owns the 0xFF46 register and copies 160 bytes from page XX00
// into OAM at 0xFE00, driving the MMU DMA port. While the DMA port address is
// not 0xFFFF the MMU locks the CPU out, so addr_select doubles as the lockout.
// Optional build macro OAM_DMA_ECHO_REMAP_EN: pages E0-FF are remapped to C0-DF;
// without it, writes of E0-FF are latched but start nothing.
// CYCLES_PER_BYTE must be at least READ_LATENCY + 2.
module oam_dma_ctrl
    import gb_mem_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned STARTUP_CYCLES  = 4
) (
    input  logic   clk,
    input  logic   rst,
    mem_if.slave   mmio_dma_if,
    mem_if.master  dma_req,
    output logic   dma_active
);

    localparam int unsigned START_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

    dma_state_t       state_q;
    logic [START_W-1:0] start_cnt_q;
    logic [7:0]       dma_reg_q;
    logic [7:0]       src_page_q;
    logic [7:0]       data_q;
    logic [15:0]      addr_q;
    logic [7:0]       wval_q;
    logic             we_q;
    logic             active_q;

    logic             reg_wr;
    logic             wr_ok;
    logic [7:0]       wr_page;
    logic             accept;
    logic             start_done;
    logic             tmr_clr;
    logic             tmr_step;

    logic             slot_last;
    logic             slot_pre_last;
    logic             slot_capture;
    logic             byte_last;
    logic [7:0]       idx;
    logic [7:0]       idx_step;

    assign reg_wr = mmio_dma_if.write_enable && (mmio_dma_if.addr_select == DMA_REG_ADDR);

`ifdef OAM_DMA_ECHO_REMAP_EN
    // Echo-RAM pages are folded onto WRAM so every write starts a transfer.
    always_comb begin
        wr_ok   = 1'b1;
        wr_page = mmio_dma_if.write_value;
        if (mmio_dma_if.write_value >= 8'hE0) begin
            wr_page = mmio_dma_if.write_value - 8'h20;
        end
    end
`else
    // Pages E0-FF are not a legal source: latched for read-back but ignored here.
    always_comb begin
        wr_ok   = (mmio_dma_if.write_value < 8'hE0);
        wr_page = mmio_dma_if.write_value;
    end
`endif

    assign accept     = reg_wr && wr_ok;
    assign start_done = (start_cnt_q == START_W'(STARTUP_CYCLES - 1));

    // A new start preempts everything; the final byte ends the transfer without stepping.
    assign tmr_clr  = (state_q == START) && !accept && start_done;
    assign tmr_step = (state_q == XFER) && !accept && !(slot_last && byte_last);

    dma_slot_timer #(
        .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
        .READ_LATENCY    (READ_LATENCY)
    ) u_slot_timer (
        .clk           (clk),
        .rst           (rst),
        .clr           (tmr_clr),
        .step          (tmr_step),
        .slot_last     (slot_last),
        .slot_pre_last (slot_pre_last),
        .slot_capture  (slot_capture),
        .byte_last     (byte_last),
        .idx           (idx),
        .idx_step      (idx_step)
    );

    // DMA register: every FF46 write is latched, even one that starts nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_reg_q <= 8'hFF;
        end else if (reg_wr) begin
            dma_reg_q <= mmio_dma_if.write_value;
        end
    end

    // Transfer FSM with registered bus outputs computed for the slot about to begin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_cnt_q <= '0;
            src_page_q  <= 8'h00;
            data_q      <= 8'h00;
            addr_q      <= DMA_IDLE_ADDR;
            wval_q      <= 8'h00;
            we_q        <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            we_q   <= 1'b0;
            wval_q <= 8'h00;
            if ((state_q == XFER) && slot_capture) begin
                data_q <= dma_req.read_out;
            end
            if (accept) begin
                state_q     <= START;
                start_cnt_q <= '0;
                src_page_q  <= wr_page;
                // A restart while locked keeps the lockout by parking on the new source.
                if (active_q) begin
                    addr_q <= dma_src_addr(wr_page, 8'h00);
                end else begin
                    addr_q <= DMA_IDLE_ADDR;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        addr_q   <= DMA_IDLE_ADDR;
                        active_q <= 1'b0;
                    end
                    START: begin
                        if (start_done) begin
                            state_q  <= XFER;
                            active_q <= 1'b1;
                            addr_q   <= dma_src_addr(src_page_q, 8'h00);
                        end else begin
                            start_cnt_q <= start_cnt_q + START_W'(1);
                        end
                    end
                    XFER: begin
                        if (slot_last && byte_last) begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                            addr_q   <= DMA_IDLE_ADDR;
                        end else if (slot_pre_last) begin
                            // Next slot is the write slot; data may arrive on this very edge.
                            addr_q <= dma_oam_addr(idx);
                            we_q   <= 1'b1;
                            wval_q <= slot_capture ? dma_req.read_out : data_q;
                        end else begin
                            addr_q <= dma_src_addr(src_page_q, idx_step);
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        addr_q   <= DMA_IDLE_ADDR;
                    end
                endcase
            end
        end
    end

    assign mmio_dma_if.read_out = dma_reg_q;
    assign dma_req.addr_select  = addr_q;
    assign dma_req.write_value  = wval_q;
    assign dma_req.write_enable = we_q;
    assign dma_active           = active_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a random source memory, an edge-indexed
// reference of expected OAM writes and of the lockout window, and a monitor
// that checks every cycle and every write pulse.
module tb_oam_dma_ctrl;
    import gb_mem_pkg::*;

    localparam int SU  = 4;
    localparam int CPB = 4;
    localparam int NB  = 160;

    typedef struct {
        int          edge_no;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk;
    logic rst;
    logic dma_active;

    mem_if mmio ();
    mem_if req ();

    oam_dma_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mmio_dma_if (mmio),
        .dma_req     (req),
        .dma_active  (dma_active)
    );

    logic [7:0] mem [0:65535];
    logic [7:0] rd_q;
    exp_t       q[$];
    int         edge_cnt  = 0;
    int         act_from  = 0;
    int         act_until = 0;
    int         pulses    = 0;
    int         total     = 0;
    int         bad       = 0;
    logic [7:0] reg_model = 8'hFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Source memory with one clock of read latency.
    always @(posedge clk) rd_q <= mem[req.addr_select];
    assign req.read_out = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic accepted(input logic [7:0] v);
`ifdef OAM_DMA_ECHO_REMAP_EN
        return 1'b1;
`else
        return v < 8'hE0;
`endif
    endfunction

    function automatic logic [7:0] page_of(input logic [7:0] v);
`ifdef OAM_DMA_ECHO_REMAP_EN
        return (v >= 8'hE0) ? v - 8'h20 : v;
`else
        return v;
`endif
    endfunction

    // Reference: a start at edge t locks from t+SU, writes byte k at edge t+SU+CPB*(k+1),
    // and releases after the last write; a later start drops every write after its edge.
    task automatic model_write(input logic [15:0] a, input logic [7:0] v, input int t);
        logic [7:0] pg;
        if (a != DMA_REG_ADDR || !accepted(v)) return;
        while (q.size() > 0 && q[$].edge_no > t) void'(q.pop_back());
        if (act_from <= t - 1 && t - 1 < act_until) begin
            act_until = t + SU + CPB * NB;
        end else begin
            act_from  = t + SU;
            act_until = t + SU + CPB * NB;
        end
        pg = page_of(v);
        for (int k = 0; k < NB; k++) begin
            q.push_back('{edge_no: t + SU + CPB * (k + 1),
                          addr: 16'hFE00 + 16'(k),
                          data: mem[{pg, 8'(k)}]});
        end
    endtask

    // Drive one MMIO write so that it is sampled at edge 'target' (0 = next edge).
    task automatic wr(input logic [15:0] a, input logic [7:0] v, input int target, output int t);
        @(negedge clk);
        while (edge_cnt + 1 < target) @(negedge clk);
        t = edge_cnt + 1;
        mmio.addr_select  = a;
        mmio.write_value  = v;
        mmio.write_enable = 1'b1;
        model_write(a, v, t);
        @(posedge clk);
        #1;
        mmio.write_enable = 1'b0;
        mmio.addr_select  = 16'h0000;
        if (a == DMA_REG_ADDR) reg_model = v;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1500 && !done; i++) begin
            @(negedge clk);
            if (edge_cnt > act_until && q.size() == 0) done = 1'b1;
        end
        chk("idle reached in time", 32'(done), 32'(1));
        chk("idle dma_active", 32'(dma_active), 32'(0));
        chk("idle addr", 32'(req.addr_select), 32'(16'hFFFF));
    endtask

    // Monitor: lockout window and read-back every cycle, scoreboard on every write pulse.
    always @(negedge clk) begin : mon
        exp_t x;
        logic exp_act;
        exp_act = (act_from <= edge_cnt) && (edge_cnt < act_until);
        chk("dma_active", 32'(dma_active), 32'(exp_act));
        if (!exp_act) begin
            chk("addr while unlocked", 32'(req.addr_select), 32'(16'hFFFF));
            chk("we while unlocked", 32'(req.write_enable), 32'(0));
        end else begin
            chk("addr not FFFF while locked", 32'(req.addr_select != 16'hFFFF), 32'(1));
        end
        chk("ff46 read-back", 32'(mmio.read_out), 32'(reg_model));
        if (req.write_enable === 1'b1) begin
            pulses++;
            chk("write was expected", 32'(q.size() != 0), 32'(1));
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("write edge", 32'(edge_cnt + 1), 32'(x.edge_no));
                chk("write addr", 32'(req.addr_select), 32'(x.addr));
                chk("write data", 32'(req.write_value), 32'(x.data));
            end
        end
    end

    initial begin
        int t;
        int t2;
        logic [15:0] a;
        logic [7:0]  v;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mmio.addr_select  = 16'h0000;
        mmio.write_value  = 8'h00;
        mmio.write_enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset read-back", 32'(mmio.read_out), 32'(8'hFF));
        chk("reset active", 32'(dma_active), 32'(0));
        chk("reset addr", 32'(req.addr_select), 32'(16'hFFFF));
        chk("reset we", 32'(req.write_enable), 32'(0));

        // Full transfer from page C1.
        pulses = 0;
        wr(DMA_REG_ADDR, 8'hC1, 0, t);
        wait_idle();
        chk("C1 pulse count", 32'(pulses), 32'(160));

        // Read-back during a transfer.
        wr(DMA_REG_ADDR, 8'h80, 0, t);
        repeat (50) @(negedge clk);
        chk("read-back mid transfer", 32'(mmio.read_out), 32'(8'h80));
        wait_idle();

        // Restart during byte 50: 50 old bytes plus a full 160 new ones.
        pulses = 0;
        wr(DMA_REG_ADDR, 8'hC0, 0, t);
        wr(DMA_REG_ADDR, 8'hC2, t + SU + CPB * 50 + 2, t2);
        wait_idle();
        chk("restart pulse count", 32'(pulses), 32'(210));

        // Echo page: remapped with the feature, ignored without it.
        wr(DMA_REG_ADDR, 8'hE3, 0, t);
        repeat (20) @(negedge clk);
        chk("E3 read-back", 32'(mmio.read_out), 32'(8'hE3));
        wait_idle();

        // Restart exactly on the final write slot: write completes, lockout continuous.
        pulses = 0;
        wr(DMA_REG_ADDR, 8'hC5, 0, t);
        wr(DMA_REG_ADDR, 8'h47, t + SU + CPB * NB, t2);
        wait_idle();
        chk("last-slot restart pulses", 32'(pulses), 32'(320));

        // Restart during START re-runs the startup count.
        wr(DMA_REG_ADDR, 8'h10, 0, t);
        wr(DMA_REG_ADDR, 8'h11, t + 2, t2);
        wait_idle();

        // Asynchronous reset during byte 37 slot 2.
        wr(DMA_REG_ADDR, 8'hC1, 0, t);
        while (edge_cnt < t + SU + CPB * 37 + 2) @(negedge clk);
        #2;
        rst = 1'b1;
        act_until = edge_cnt;
        while (q.size() > 0 && q[$].edge_no > edge_cnt) void'(q.pop_back());
        reg_model = 8'hFF;
        #1;
        chk("rst addr same cycle", 32'(req.addr_select), 32'(16'hFFFF));
        chk("rst we same cycle", 32'(req.write_enable), 32'(0));
        chk("rst active same cycle", 32'(dma_active), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("no writes after reset", 32'(q.size()), 32'(0));

        // Random writes, some to other registers, some illegal pages, random spacing.
        for (int n = 0; n < 8; n++) begin
            a = ($urandom_range(0, 4) == 0) ? 16'hFF47 : DMA_REG_ADDR;
            v = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 700)) @(negedge clk);
            wr(a, v, 0, t);
        end
        wait_idle();
        chk("scoreboard drained", 32'(q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
